// File: rtl/div_ctrl_pkg.sv
// Shared types for the divider request controller: FSM states, the response
// record and the divide-by-zero result.
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    RESP
  } state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
    logic                 dbz;
    logic                 timeout;
  } div_rsp_t;

  // x/0 reports an all-ones quotient and returns the dividend as remainder.
  function automatic div_rsp_t dbz_result(input logic [DIV_WIDTH-1:0] a);
    div_rsp_t res;
    res.q       = '1;
    res.r       = a;
    res.dbz     = 1'b1;
    res.timeout = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/div_req_ctrl_if.sv
// Signal bundle between the divider request controller, its upstream/downstream
// channels and the iterative divider.
interface div_req_ctrl_if #(
  parameter int W = 32
);
  // req_*/rsp_* are valid/ready channels: a transfer happens on a rising edge
  // where valid & ready are both high; the source holds valid and data stable
  // until that edge. div_start/div_ack are single-cycle pulses; div_complete
  // is a level held by the divider until ack or the next start.
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic         div_start;
  logic         div_ack;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         div_complete;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_dbz;
  logic         rsp_timeout;

  logic         busy;

  modport master (
    input  req_valid, req_a, req_b, div_q, div_r, div_complete, rsp_ready,
    output req_ready, div_start, div_ack, div_a, div_b,
           rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_timeout, busy
  );

  modport slave (
    output req_valid, req_a, req_b, div_q, div_r, div_complete, rsp_ready,
    input  req_ready, div_start, div_ack, div_a, div_b,
           rsp_valid, rsp_q, rsp_r, rsp_dbz, rsp_timeout, busy
  );

endinterface

// File: rtl/div_timeout_ctr.sv
// Saturating WAIT-cycle counter; expired is high on the last permitted cycle.
module div_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 72
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/div_req_ctrl.sv
// Initiator-side controller for the iterative divider: accepts operand pairs,
// runs the start/complete/ack handshake and returns Q/R with dbz/timeout flags.
module div_req_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int C_WIDTH        = DIV_WIDTH,
  parameter int TIMEOUT_CYCLES = 72
) (
  input  logic           clk,
  input  logic           rst,
  div_req_ctrl_if.master bus,
  output state_t         state_dbg
);

  state_t             state;
  state_t             state_nxt;
  div_rsp_t           rsp;
  logic [C_WIDTH-1:0] div_a;
  logic [C_WIDTH-1:0] div_b;
  logic               accept;
  logic               expired;

  assign accept = bus.req_valid && (state == IDLE);

  div_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.req_b == '0) ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.div_complete || expired) state_nxt = ACK;
      ACK:     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Complete is tested before expiry so a result arriving on the last cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_a <= '0;
      div_b <= '0;
      rsp   <= '0;
    end else begin
      if (accept) begin
        div_a <= bus.req_a;
        div_b <= bus.req_b;
        if (bus.req_b == '0) rsp <= dbz_result(bus.req_a);
      end
      if (state == WAIT) begin
        if (bus.div_complete) begin
          rsp <= '{q: bus.div_q, r: bus.div_r, dbz: 1'b0, timeout: 1'b0};
        end else if (expired) begin
          rsp <= '{q: '0, r: '0, dbz: 1'b0, timeout: 1'b1};
        end
      end
      if ((state == RESP) && bus.rsp_ready) begin
        rsp.dbz     <= 1'b0;
        rsp.timeout <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.div_start   = (state == ISSUE);
  assign bus.div_ack     = (state == ACK);
  assign bus.div_a       = div_a;
  assign bus.div_b       = div_b;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_q       = rsp.q;
  assign bus.rsp_r       = rsp.r;
  assign bus.rsp_dbz     = rsp.dbz;
  assign bus.rsp_timeout = rsp.timeout;
  assign bus.busy        = (state != IDLE);
  assign state_dbg       = state;

endmodule
